// File: rtl/seg8_load_if.sv
// ----------------------------------------------------------------------------
// seg8_load_if
// Load bus between a word producer and the seg8_scan_driver.
//   load      1-cycle strobe capturing digits/dp_en/blank_en
//   digits    8 hex nibbles, digits[4i+3:4i] = digit i (7..4 left, 3..0 right)
//   dp_en     per-digit decimal point, bit i = digit i
//   blank_en  per-digit blank, bit i = digit i
//   pending   captured word waiting for the next frame commit
// ----------------------------------------------------------------------------
interface seg8_load_if;
   logic        load;
   logic [31:0] digits;
   logic [7:0]  dp_en;
   logic [7:0]  blank_en;
   logic        pending;

   modport master (output load, output digits, output dp_en, output blank_en,
                   input  pending);
   modport slave  (input  load, input  digits, input  dp_en, input  blank_en,
                   output pending);
endinterface

// File: rtl/seg8_scan_driver.sv
// ----------------------------------------------------------------------------
// seg8_scan_driver
// Time-multiplexed driver for two 4-digit seven-segment banks. A loaded word
// is held pending and committed only at a frame boundary (digit index wrap
// 3->0) so a frame is never torn. Both banks are scanned in parallel, one
// digit slot per DIV_CNT clocks.
//   clk           system clock
//   rst           asynchronous active-low reset
//   bus           seg8_load_if.slave (load, digits, dp_en, blank_en, pending)
//   frame_tick    high during the last cycle of a frame (idx 3, last count)
//   a_to_g_left   left bank segments, bit0=a .. bit6=g, bit7=dp, active-high
//   a_to_g_right  right bank segments, same encoding
//   leftseg       left bank one-hot digit select (slot i -> digit 4+i)
//   rightseg      right bank one-hot digit select (slot i -> digit i)
// ----------------------------------------------------------------------------
module seg8_scan_driver #(
   parameter int unsigned DIV_CNT = 100000
) (
   input  logic        clk,
   input  logic        rst,
   seg8_load_if.slave  bus,
   output logic        frame_tick,
   output logic [7:0]  a_to_g_left,
   output logic [7:0]  a_to_g_right,
   output logic [3:0]  leftseg,
   output logic [3:0]  rightseg
);

   localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;

   typedef struct packed {
      logic [31:0] digits;
      logic [7:0]  dp;
      logic [7:0]  blank;
   } word_t;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   word_t         r_pend;
   word_t         r_disp;
   logic          r_pending;

   logic          w_slot_end;
   logic          w_frame;
   word_t         w_new;
   logic [2:0]    w_lidx;
   logic [7:0]    w_left_seg;
   logic [7:0]    w_right_seg;
   logic [3:0]    w_left_sel;
   logic [3:0]    w_right_sel;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

   assign w_slot_end  = (r_cnt == CW'(DIV_CNT - 1));
   assign w_frame     = w_slot_end && (r_idx == 2'd3);
   assign w_new       = {bus.digits, bus.dp_en, bus.blank_en};
   assign frame_tick  = w_frame;
   assign bus.pending = r_pending;

   // Slot counter and digit index.
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Pending/display words. A load landing on the boundary bypasses the
   // pending register so it is shown in the very next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend    <= '0;
         r_disp    <= '0;
         r_pending <= 1'b0;
      end else if (bus.load) begin
         if (w_frame) begin
            r_disp    <= w_new;
            r_pending <= 1'b0;
         end else begin
            r_pend    <= w_new;
            r_pending <= 1'b1;
         end
      end else if (w_frame && r_pending) begin
         r_disp    <= r_pend;
         r_pending <= 1'b0;
      end
   end

   // Decode of the current slot; left bank shows digit 4+idx, right digit idx.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_lidx      = {1'b1, r_idx};
      w_left_seg  = 8'h00;
      w_right_seg = 8'h00;
      w_left_sel  = 4'b0000;
      w_right_sel = 4'b0000;
      if (!r_disp.blank[w_lidx]) begin
         w_left_seg = {r_disp.dp[w_lidx],
                       hex_to_seg(r_disp.digits[{w_lidx, 2'b00} +: 4])};
         w_left_sel = 4'b0001 << r_idx;
      end
      if (!r_disp.blank[{1'b0, r_idx}]) begin
         w_right_seg = {r_disp.dp[{1'b0, r_idx}],
                        hex_to_seg(r_disp.digits[{1'b0, r_idx, 2'b00} +: 4])};
         w_right_sel = 4'b0001 << r_idx;
      end
   end

   // Segments and selects share one register stage, so they always change on
   // the same edge and no cycle mixes one slot's segments with another's select.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_to_g_left  <= '0;
         a_to_g_right <= '0;
         leftseg      <= '0;
         rightseg     <= '0;
      end else begin
         a_to_g_left  <= w_left_seg;
         a_to_g_right <= w_right_seg;
         leftseg      <= w_left_sel;
         rightseg     <= w_right_sel;
      end
   end

endmodule

// File: tb/tb_seg8_scan_driver.sv
module tb_seg8_scan_driver;
   localparam int D     = 4;
   localparam int FRAME = 4 * D;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick;
   logic [7:0] a_to_g_left, a_to_g_right;
   logic [3:0] leftseg, rightseg;

   seg8_load_if bus ();

   seg8_scan_driver #(.DIV_CNT(D)) dut (
      .clk(clk), .rst(rst), .bus(bus), .frame_tick(frame_tick),
      .a_to_g_left(a_to_g_left), .a_to_g_right(a_to_g_right),
      .leftseg(leftseg), .rightseg(rightseg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (time-arithmetic view) ----------------
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          m_t;
   logic [47:0] m_disp, m_pword;
   logic        m_pend;
   logic [23:0] m_out;

   function automatic logic [23:0] slot_out(input logic [47:0] w, input int idx);
      logic [31:0] d;  logic [7:0] dp, bl;
      logic [7:0]  l, r;  logic [3:0] ls, rs;
      int          li;
      d  = w[47:16]; dp = w[15:8]; bl = w[7:0];
      li = idx + 4;
      l = 8'h00; r = 8'h00; ls = 4'h0; rs = 4'h0;
      if (!bl[li])  begin l = {dp[li],  seg_tab[d[li*4 +: 4]]};  ls = 4'(1 << idx); end
      if (!bl[idx]) begin r = {dp[idx], seg_tab[d[idx*4 +: 4]]}; rs = 4'(1 << idx); end
      return {l, r, ls, rs};
   endfunction

   task automatic model_reset();
      m_t = 0; m_disp = '0; m_pword = '0; m_pend = 1'b0; m_out = '0;
   endtask

   // One clock: advance the model with the inputs the DUT is about to sample,
   // then compare every output just after the edge.
   task automatic tick();
      logic        boundary;
      logic [47:0] w;
      boundary = (m_t % FRAME) == FRAME - 1;
      w        = {bus.digits, bus.dp_en, bus.blank_en};
      m_out    = slot_out(m_disp, (m_t / D) % 4);
      if (bus.load) begin
         if (boundary) begin m_disp = w; m_pend = 1'b0; end
         else begin m_pword = w; m_pend = 1'b1; end
      end else if (boundary && m_pend) begin
         m_disp = m_pword; m_pend = 1'b0;
      end
      m_t++;
      @(posedge clk); #1;
      check("cycle_model",
            32'({frame_tick, bus.pending, a_to_g_left, a_to_g_right, leftseg, rightseg}),
            32'({((m_t % FRAME) == FRAME - 1), m_pend, m_out}));
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
      bus.digits = d; bus.dp_en = dp; bus.blank_en = bl; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   // Run until frame_tick is seen, then through the boundary edge.
   task automatic wait_frame();
      bit found = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (frame_tick) begin found = 1; break; end
         tick();
      end
      if (!found) check("frame_tick_timeout", 32'(0), 32'(1));
      tick();
   endtask

   task automatic check_slot(input string name, input int s, input logic [7:0] l,
                             input logic [7:0] r, input logic [3:0] ls, input logic [3:0] rs);
      check($sformatf("%s_s%0d_left", name, s),  32'(a_to_g_left),  32'(l));
      check($sformatf("%s_s%0d_right", name, s), 32'(a_to_g_right), 32'(r));
      check($sformatf("%s_s%0d_lsel", name, s),  32'(leftseg),      32'(ls));
      check($sformatf("%s_s%0d_rsel", name, s),  32'(rightseg),     32'(rs));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [31:0]      digits;
      logic [7:0]       dp;
      logic [7:0]       blank;
      logic [3:0][7:0]  l;
      logic [3:0][7:0]  r;
      logic [3:0][3:0]  ls;
      logic [3:0][3:0]  rs;
   } vec_t;

   vec_t vecs [4];

   initial begin
      vecs[0] = '{32'h89AB_0123, 8'h00, 8'h00, 32'h7F6F777C, 32'h3F065B4F, 16'h8421, 16'h8421};
      vecs[1] = '{32'h2222_2222, 8'h00, 8'h00, 32'h5B5B5B5B, 32'h5B5B5B5B, 16'h8421, 16'h8421};
      vecs[2] = '{32'h0000_0000, 8'h81, 8'h02, 32'hBF3F3F3F, 32'h3F3F00BF, 16'h8421, 16'h8401};
      vecs[3] = '{32'h0123_4567, 8'h0F, 8'hF0, 32'h00000000, 32'hE6EDFD87, 16'h0000, 16'h8421};

      bus.load = 1'b0; bus.digits = '0; bus.dp_en = '0; bus.blank_en = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            32'({frame_tick, bus.pending, a_to_g_left, a_to_g_right, leftseg, rightseg}), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      // First registered slot after reset: blank display shows 0 everywhere.
      tick();
      check_slot("first", 0, 8'h3F, 8'h3F, 4'b0001, 4'b0001);
      repeat (D) tick();
      check_slot("first", 1, 8'h3F, 8'h3F, 4'b0010, 4'b0010);

      // Table: load mid-frame, pending until commit, then walk all four slots.
      foreach (vecs[k]) begin
         wait_frame();
         tick(); tick();
         do_load(vecs[k].digits, vecs[k].dp, vecs[k].blank);
         check($sformatf("vec%0d_pending_set", k), 32'(bus.pending), 32'(1));
         wait_frame();
         check($sformatf("vec%0d_pending_clr", k), 32'(bus.pending), 32'(0));
         tick();
         for (int s = 0; s < 4; s++) begin
            check_slot($sformatf("vec%0d", k), s, vecs[k].l[s], vecs[k].r[s],
                       vecs[k].ls[s], vecs[k].rs[s]);
            repeat (D) tick();
         end
      end

      // Two loads in one frame: last one wins.
      wait_frame();
      tick();
      do_load(32'h1111_1111, 8'h00, 8'h00);
      repeat (3) tick();
      do_load(32'h2222_2222, 8'h00, 8'h00);
      wait_frame();
      tick();
      for (int s = 0; s < 4; s++) begin
         check_slot("dbl", s, 8'h5B, 8'h5B, 4'(1 << s), 4'(1 << s));
         repeat (D) tick();
      end

      // Load exactly on the frame_tick cycle: straight to display, no pending.
      begin
         bit found = 0;
         for (int i = 0; i < 3 * FRAME; i++) begin
            if (frame_tick) begin found = 1; break; end
            tick();
         end
         check("ontick_found", 32'(found), 32'(1));
      end
      do_load(32'hFFFF_FFFF, 8'h00, 8'h00);
      check("ontick_pending", 32'(bus.pending), 32'(0));
      tick();
      check_slot("ontick", 0, 8'h71, 8'h71, 4'b0001, 4'b0001);

      // Reset pulse in the middle of slot 2.
      wait_frame();
      repeat (2 * D + 1) tick();
      #2 rst = 1'b0;
      #1;
      check("midrst_outputs",
            32'({frame_tick, bus.pending, a_to_g_left, a_to_g_right, leftseg, rightseg}), 32'(0));
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < D; i++) begin
         tick();
         check($sformatf("midrst_slot0_%0d", i), 32'({leftseg, a_to_g_left}), 32'({4'b0001, 8'h3F}));
      end
      tick();
      check("midrst_slot1", 32'({leftseg, rightseg}), 32'({4'b0010, 4'b0010}));

      // Randomized traffic, including loads on the boundary cycle.
      for (int i = 0; i < 600; i++) begin
         if ((frame_tick && $urandom_range(0, 2) == 0) || $urandom_range(0, 9) == 0)
            do_load($urandom, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom : 0));
         else
            tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
